// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing constants and the half-open range decode
// shared by the sync and blank outputs.
package vga_timing_pkg;

  localparam int unsigned CNT_W     = 10;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // True when lo <= v < hi, all unsigned counter-width values.
  function automatic logic in_range(input logic [CNT_W-1:0] v,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster position/sync bundle produced by vga_timing_gen and consumed by
// the colour mapper, sprite addressing and maze renderer.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic             pixel_clk;
  logic             hs;
  logic             vs;
  logic             blank;
  logic             sync;
  logic [CNT_W-1:0] DrawX;
  logic [CNT_W-1:0] DrawY;
  logic             frame_start;
  logic [7:0]       frame_count;

  modport master (
    output pixel_clk, hs, vs, blank, sync, DrawX, DrawY, frame_start, frame_count
  );

  modport slave (
    input  pixel_clk, hs, vs, blank, sync, DrawX, DrawY, frame_start, frame_count
  );

endinterface

// File: rtl/wrap_counter.sv
// Enabled up-counter that returns to zero after MAX; wrap flags the
// enabled cycle on which the return happens.
module wrap_counter #(
  parameter int unsigned      WIDTH = 10,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  assign wrap = en && (count == MAX);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: half-rate pixel enable, horizontal/vertical
// counters and registered sync/blank/frame outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int unsigned H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BACK    = vga_timing_pkg::H_BACK,
  parameter int unsigned V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int unsigned V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic             Clk,
  input  logic             Reset,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_bad_timing
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] H_SYNC_LO  = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] H_SYNC_HI  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] V_SYNC_LO  = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] V_SYNC_HI  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic             pix_en;
  logic [CNT_W-1:0] hc;
  logic [CNT_W-1:0] vc;
  logic             h_wrap;
  logic             v_wrap;
  logic [CNT_W-1:0] hc_next;
  logic [CNT_W-1:0] vc_next;

  logic             hs_q;
  logic             vs_q;
  logic             blank_q;
  logic             frame_start_q;
  logic [7:0]       frame_count_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pix_en <= 1'b0;
    end else begin
      pix_en <= ~pix_en;
    end
  end

  wrap_counter #(
    .WIDTH (CNT_W),
    .MAX   (CNT_W'(H_TOTAL - 1))
  ) u_hcnt (
    .Clk   (Clk),
    .Reset (Reset),
    .en    (pix_en),
    .count (hc),
    .wrap  (h_wrap)
  );

  wrap_counter #(
    .WIDTH (CNT_W),
    .MAX   (CNT_W'(V_TOTAL - 1))
  ) u_vcnt (
    .Clk   (Clk),
    .Reset (Reset),
    .en    (h_wrap),
    .count (vc),
    .wrap  (v_wrap)
  );

  // Mirror the counters' next state so the decodes land on the same edge
  // as the counters themselves rather than one Clk later.
  always_comb begin
    hc_next = hc;
    vc_next = vc;
    if (h_wrap) begin
      hc_next = '0;
    end else if (pix_en) begin
      hc_next = hc + CNT_W'(1);
    end
    if (v_wrap) begin
      vc_next = '0;
    end else if (h_wrap) begin
      vc_next = vc + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b1;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      hs_q          <= ~in_range(hc_next, H_SYNC_LO, H_SYNC_HI);
      vs_q          <= ~in_range(vc_next, V_SYNC_LO, V_SYNC_HI);
      blank_q       <= in_range(hc_next, '0, H_VIS_END) &&
                       in_range(vc_next, '0, V_VIS_END);
      frame_start_q <= v_wrap;
      frame_count_q <= frame_count_q + 8'(v_wrap);
    end
  end

  assign vga.pixel_clk   = pix_en;
  assign vga.hs          = hs_q;
  assign vga.vs          = vs_q;
  assign vga.blank       = blank_q;
  assign vga.sync        = 1'b0;
  assign vga.DrawX       = hc;
  assign vga.DrawY       = vc;
  assign vga.frame_start = frame_start_q;
  assign vga.frame_count = frame_count_q;

endmodule
